// File: rtl/fsic_serdes_cfg_pkg.sv
// Shared encodings for the FSIC SERDES config master: FSM states, control bit positions,
// and the default control register offset.
package fsic_serdes_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      RD_A  = 3'd2,
      RD_D  = 3'd3,
      CHECK = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } cfg_state_e;

   localparam int RXEN_BIT           = 0;
   localparam int TXEN_BIT           = 1;
   localparam int DEFAULT_REG_OFFSET = 0;

endpackage

// File: rtl/fsic_cfg_watchdog.sv
// Saturating cycle counter; expired stays high once pTIMEOUT is reached until cleared.
module fsic_cfg_watchdog #(
   parameter int pTIMEOUT = 255
) (
   input  logic axi_clk,
   input  logic axi_reset_n,
   input  logic clear,
   output logic expired
);

   localparam int CW = (pTIMEOUT > 0) ? $clog2(pTIMEOUT + 1) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (cnt_q != CW'(pTIMEOUT)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == CW'(pTIMEOUT));

endmodule

// File: rtl/fsic_serdes_cfg_master.sv
// AXI-Lite initiator that writes the IO SERDES control register and, with
// FSIC_SERDES_CFG_READBACK_EN defined, polls it by read until the enables match.
module fsic_serdes_cfg_master
   import fsic_serdes_cfg_pkg::*;
#(
   parameter int pADDR_WIDTH = 15,
   parameter int pDATA_WIDTH = 32,
   parameter int pREG_OFFSET = DEFAULT_REG_OFFSET,
   parameter int pMAX_RETRY  = 7,
   parameter int pTIMEOUT    = 255
) (
   input  logic                     axi_clk,
   input  logic                     axi_reset_n,
   input  logic                     start,
   input  logic                     cfg_rxen,
   input  logic                     cfg_txen,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [pDATA_WIDTH-1:0]   rd_data,
   output logic                     cc_is_enable,
   output logic                     axi_awvalid,
   output logic [pADDR_WIDTH-1:0]   axi_awaddr,
   input  logic                     axi_awready,
   output logic                     axi_wvalid,
   output logic [pDATA_WIDTH-1:0]   axi_wdata,
   output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
   input  logic                     axi_wready,
   output logic                     axi_arvalid,
   output logic [pADDR_WIDTH-1:0]   axi_araddr,
   input  logic                     axi_arready,
   input  logic                     axi_rvalid,
   input  logic [pDATA_WIDTH-1:0]   axi_rdata,
   output logic                     axi_rready,
   output cfg_state_e               state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valids are decoded from state and never wait on ready.
   cfg_state_e state_q, state_d;
   logic       rxen_q, txen_q;
   logic       aw_done_q, w_done_q, aw_done_d, w_done_d;
   logic       start_ok, wd_clear, wd_expired;

   assign start_ok     = (state_q == IDLE) && start;
   assign axi_awvalid  = (state_q == WR) && !aw_done_q;
   assign axi_wvalid   = (state_q == WR) && !w_done_q;
   assign aw_done_d    = aw_done_q | (axi_awvalid & axi_awready);
   assign w_done_d     = w_done_q | (axi_wvalid & axi_wready);
   assign busy         = state_q inside {WR, RD_A, RD_D, CHECK};
   assign done         = (state_q == DONE);
   assign cc_is_enable = state_q inside {WR, RD_A, RD_D};
   assign axi_awaddr   = pADDR_WIDTH'(pREG_OFFSET);
   assign axi_araddr   = pADDR_WIDTH'(pREG_OFFSET);
   assign axi_wstrb    = '1;
   assign state_dbg    = state_q;

   always_comb begin
      axi_wdata           = '0;
      axi_wdata[RXEN_BIT] = rxen_q;
      axi_wdata[TXEN_BIT] = txen_q;
   end

`ifdef FSIC_SERDES_CFG_READBACK_EN
   localparam int RW = (pMAX_RETRY > 0) ? $clog2(pMAX_RETRY + 1) : 1;

   logic [RW-1:0] retry_q;
   logic          rd_match;

   assign axi_arvalid = (state_q == RD_A);
   assign axi_rready  = (state_q == RD_D);
   assign rd_match    = (rd_data[TXEN_BIT] == txen_q) && (rd_data[RXEN_BIT] == rxen_q);

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         retry_q <= '0;
         rd_data <= '0;
      end else begin
         if (start_ok) begin
            retry_q <= '0;
         end else if ((state_q == CHECK) && !rd_match) begin
            retry_q <= retry_q + 1'b1;
         end
         if ((state_q == RD_D) && axi_rvalid) begin
            rd_data <= axi_rdata;
         end
      end
   end
`else
   logic unused_rd;

   assign axi_arvalid = 1'b0;
   assign axi_rready  = 1'b0;
   assign rd_data     = '0;
   assign unused_rd   = ^{axi_arready, axi_rvalid, axi_rdata, (pMAX_RETRY > 0)};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = WR;
         WR: begin
            if (wd_expired) begin
               state_d = ERR;
            end else if (aw_done_d && w_done_d) begin
`ifdef FSIC_SERDES_CFG_READBACK_EN
               state_d = RD_A;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef FSIC_SERDES_CFG_READBACK_EN
         RD_A: begin
            if (wd_expired)       state_d = ERR;
            else if (axi_arready) state_d = RD_D;
         end
         RD_D: begin
            if (wd_expired)      state_d = ERR;
            else if (axi_rvalid) state_d = CHECK;
         end
         CHECK: begin
            if (rd_match)                        state_d = DONE;
            else if (retry_q == RW'(pMAX_RETRY)) state_d = ERR;
            else                                 state_d = RD_A;
         end
`endif
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         rxen_q    <= 1'b0;
         txen_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         error     <= 1'b0;
      end else begin
         if (start_ok) begin
            rxen_q    <= cfg_rxen;
            txen_q    <= cfg_txen;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error     <= 1'b0;
         end else if (state_q == WR) begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
         end
         // error rises with the ERR state and holds until the next accepted start
         if ((state_d == ERR) && (state_q != ERR)) begin
            error <= 1'b1;
         end
      end
   end

   // Every state change restarts the per-handshake timeout.
   assign wd_clear = (state_d != state_q);

   fsic_cfg_watchdog #(
      .pTIMEOUT (pTIMEOUT)
   ) u_watchdog (
      .axi_clk     (axi_clk),
      .axi_reset_n (axi_reset_n),
      .clear       (wd_clear),
      .expired     (wd_expired)
   );

endmodule

// File: tb/tb_fsic_serdes_cfg_master.sv
// Directed bench for fsic_serdes_cfg_master with a delay-configurable AXI-Lite slave;
// readback scenarios are active when FSIC_SERDES_CFG_READBACK_EN is defined.
module tb_fsic_serdes_cfg_master;
   import fsic_serdes_cfg_pkg::*;

`ifdef FSIC_SERDES_CFG_READBACK_EN
   localparam int         RB     = 3;
   localparam int         TO_LAT = 257;
   localparam cfg_state_e RST_AT = RD_D;
`else
   localparam int         RB     = 0;
   localparam int         TO_LAT = 256;
   localparam cfg_state_e RST_AT = WR;
`endif

   typedef struct {
      logic        rx;
      logic        tx;
      int          awd;
      int          wd;
      logic [31:0] exp_wdata;
      int          exp_lat;
   } vec_t;

   logic        axi_clk     = 1'b0;
   logic        axi_reset_n = 1'b0;
   logic        start       = 1'b0;
   logic        cfg_rxen    = 1'b0;
   logic        cfg_txen    = 1'b0;
   logic        busy, done, error, cc_is_enable;
   logic [31:0] rd_data;
   logic        axi_awvalid, axi_wvalid, axi_arvalid, axi_rready;
   logic [14:0] axi_awaddr, axi_araddr;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_awready = 1'b0;
   logic        axi_wready  = 1'b0;
   logic        axi_arready = 1'b0;
   logic        axi_rvalid  = 1'b0;
   logic [31:0] axi_rdata   = '0;
   cfg_state_e  state_dbg;

   int          aw_delay = 0, w_delay = 0;
   bit          ar_block = 0, r_block = 0;
   logic [31:0] rd_default = '0;
   logic [31:0] rq[$];
   int          aw_cnt = 0, w_cnt = 0;
   int          aw_hs = 0, w_hs = 0, aw_vcyc = 0, w_vcyc = 0, ar_hs = 0, rd_hs = 0, done_cnt = 0;
   int          tests = 0, failed = 0;

   vec_t        vecs[5];

   fsic_serdes_cfg_master dut (
      .axi_clk      (axi_clk),
      .axi_reset_n  (axi_reset_n),
      .start        (start),
      .cfg_rxen     (cfg_rxen),
      .cfg_txen     (cfg_txen),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .rd_data      (rd_data),
      .cc_is_enable (cc_is_enable),
      .axi_awvalid  (axi_awvalid),
      .axi_awaddr   (axi_awaddr),
      .axi_awready  (axi_awready),
      .axi_wvalid   (axi_wvalid),
      .axi_wdata    (axi_wdata),
      .axi_wstrb    (axi_wstrb),
      .axi_wready   (axi_wready),
      .axi_arvalid  (axi_arvalid),
      .axi_araddr   (axi_araddr),
      .axi_arready  (axi_arready),
      .axi_rvalid   (axi_rvalid),
      .axi_rdata    (axi_rdata),
      .axi_rready   (axi_rready),
      .state_dbg    (state_dbg)
   );

   // clock
   always #5 axi_clk = ~axi_clk;

   // Slave model: readies are set on the falling edge so the transfer lands on the next rising edge.
   always @(negedge axi_clk) begin
      if (axi_awvalid) begin
         axi_awready = (aw_cnt >= aw_delay);
         aw_vcyc++;
         if (axi_awready) aw_hs++;
         aw_cnt++;
      end else begin
         axi_awready = 1'b0;
         aw_cnt = 0;
      end
      if (axi_wvalid) begin
         axi_wready = (w_cnt >= w_delay);
         w_vcyc++;
         if (axi_wready) w_hs++;
         w_cnt++;
      end else begin
         axi_wready = 1'b0;
         w_cnt = 0;
      end
      axi_arready = axi_arvalid && !ar_block;
      if (axi_arvalid && axi_arready) ar_hs++;
      if (axi_rready && !r_block) begin
         axi_rvalid = 1'b1;
         if (rq.size() > 0) axi_rdata = rq.pop_front();
         else               axi_rdata = rd_default;
         rd_hs++;
      end else begin
         axi_rvalid = 1'b0;
      end
      if (done) done_cnt++;
   end

   function automatic logic [7:0] outs();
      return {busy, done, error, cc_is_enable, axi_awvalid, axi_wvalid, axi_arvalid, axi_rready};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one start and waits (bounded) for done or error; lat counts rising edges after the start edge.
   task automatic run_txn(input logic rx, input logic tx, input int restart_at, output int lat,
                          output logic [31:0] wdata0, output logic err0, output logic busy0);
      @(negedge axi_clk);
      aw_hs = 0; w_hs = 0; aw_vcyc = 0; w_vcyc = 0; ar_hs = 0; rd_hs = 0; done_cnt = 0;
      cfg_rxen = rx;
      cfg_txen = tx;
      start    = 1'b1;
      @(negedge axi_clk);
      start  = 1'b0;
      wdata0 = axi_wdata;
      err0   = error;
      busy0  = busy;
      lat    = -1;
      for (int k = 0; k < 1000; k++) begin
         if (done || error) begin
            lat = k;
            break;
         end
         if (k == restart_at) begin
            start    = 1'b1;
            cfg_rxen = ~rx;
            cfg_txen = ~tx;
         end else begin
            start = 1'b0;
         end
         @(negedge axi_clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] wd0;
      logic        err0, busy0;
      bit          found;

      vecs[0] = '{1'b1, 1'b1, 0, 0, 32'h3, 1 + RB};
      vecs[1] = '{1'b1, 1'b0, 3, 0, 32'h1, 4 + RB};
      vecs[2] = '{1'b0, 1'b1, 0, 2, 32'h2, 3 + RB};
      vecs[3] = '{1'b0, 1'b0, 1, 1, 32'h0, 2 + RB};
      vecs[4] = '{1'b1, 1'b1, 2, 5, 32'h3, 6 + RB};

      // reset
      repeat (3) @(negedge axi_clk);
      check("reset_outputs", 32'(outs()), 32'h0);
      check("reset_rd_data", rd_data, 32'h0);
      check("reset_state", 32'(state_dbg), 32'(IDLE));
      axi_reset_n = 1'b1;
      repeat (2) @(negedge axi_clk);

      // table-driven transactions
      for (int i = 0; i < 5; i++) begin
         aw_delay   = vecs[i].awd;
         w_delay    = vecs[i].wd;
         rd_default = vecs[i].exp_wdata;
         rq.delete();
         run_txn(vecs[i].rx, vecs[i].tx, -1, lat, wd0, err0, busy0);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_wdata", i), wd0, vecs[i].exp_wdata);
         check($sformatf("v%0d_busy_after_start", i), 32'(busy0), 32'h1);
         check($sformatf("v%0d_error_after_start", i), 32'(err0), 32'h0);
         check($sformatf("v%0d_error_at_done", i), 32'(error), 32'h0);
         check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'h0);
         check($sformatf("v%0d_wstrb", i), 32'(axi_wstrb), 32'hF);
         check($sformatf("v%0d_awaddr", i), 32'(axi_awaddr), 32'h0);
         check($sformatf("v%0d_aw_valid_cycles", i), 32'(aw_vcyc), 32'(vecs[i].awd + 1));
         check($sformatf("v%0d_w_valid_cycles", i), 32'(w_vcyc), 32'(vecs[i].wd + 1));
         check($sformatf("v%0d_aw_handshakes", i), 32'(aw_hs), 32'h1);
         check($sformatf("v%0d_w_handshakes", i), 32'(w_hs), 32'h1);
         check($sformatf("v%0d_rd_data", i), rd_data, (RB > 0) ? vecs[i].exp_wdata : 32'h0);
         check($sformatf("v%0d_ar_handshakes", i), 32'(ar_hs), (RB > 0) ? 32'h1 : 32'h0);
         repeat (2) @(negedge axi_clk);
         check($sformatf("v%0d_done_pulses", i), 32'(done_cnt), 32'h1);
         check($sformatf("v%0d_idle_outputs", i), 32'(outs()), 32'h0);
         check($sformatf("v%0d_idle_state", i), 32'(state_dbg), 32'(IDLE));
      end

      // start while busy is ignored
      aw_delay = 3; w_delay = 0; rd_default = 32'h3;
      run_txn(1'b1, 1'b1, 1, lat, wd0, err0, busy0);
      check("busy_start_latency", 32'(lat), 32'(4 + RB));
      check("busy_start_wdata", axi_wdata, 32'h3);
      check("busy_start_aw_handshakes", 32'(aw_hs), 32'h1);
      repeat (3) @(negedge axi_clk);
      check("busy_start_done_pulses", 32'(done_cnt), 32'h1);
      check("busy_start_idle", 32'(state_dbg), 32'(IDLE));

      // watchdog timeout
      ar_block = 1'b1;
      aw_delay = (RB > 0) ? 0 : 2000;
      run_txn(1'b1, 1'b0, -1, lat, wd0, err0, busy0);
      check("timeout_latency", 32'(lat), 32'(TO_LAT));
      check("timeout_outputs", 32'(outs()), 32'h20);
      @(negedge axi_clk);
      check("timeout_error_held", 32'(error), 32'h1);
      check("timeout_no_done", 32'(done_cnt), 32'h0);
      ar_block = 1'b0;
      aw_delay = 0;
      rd_default = 32'h1;
      run_txn(1'b1, 1'b0, -1, lat, wd0, err0, busy0);
      check("recover_error_cleared", 32'(err0), 32'h0);
      check("recover_latency", 32'(lat), 32'(1 + RB));
      check("recover_error_at_done", 32'(error), 32'h0);

`ifdef FSIC_SERDES_CFG_READBACK_EN
      // two mismatching reads, then a match
      rd_default = 32'h3;
      rq.delete();
      rq.push_back(32'h1);
      rq.push_back(32'h1);
      run_txn(1'b1, 1'b1, -1, lat, wd0, err0, busy0);
      check("retry_latency", 32'(lat), 32'd10);
      check("retry_reads", 32'(ar_hs), 32'd3);
      check("retry_rd_data", rd_data, 32'h3);
      check("retry_error", 32'(error), 32'h0);

      // readback never matches: pMAX_RETRY+1 reads, then error
      rd_default = 32'h0;
      run_txn(1'b0, 1'b1, -1, lat, wd0, err0, busy0);
      check("exhaust_wdata", wd0, 32'h2);
      check("exhaust_latency", 32'(lat), 32'd25);
      check("exhaust_reads", 32'(ar_hs), 32'd8);
      check("exhaust_error", 32'(error), 32'h1);
      repeat (2) @(negedge axi_clk);
      check("exhaust_no_done", 32'(done_cnt), 32'h0);
`endif

      // asynchronous reset mid-transaction
      @(negedge axi_clk);
      aw_delay   = (RB > 0) ? 0 : 2000;
      r_block    = 1'b1;
      rd_default = 32'h3;
      cfg_rxen   = 1'b1;
      cfg_txen   = 1'b1;
      start      = 1'b1;
      @(negedge axi_clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (state_dbg == RST_AT) begin
            found = 1'b1;
            break;
         end
         @(negedge axi_clk);
      end
      check("reset_reach_state", 32'(found), 32'h1);
      #2 axi_reset_n = 1'b0;
      #1;
      check("midreset_outputs", 32'(outs()), 32'h0);
      check("midreset_rd_data", rd_data, 32'h0);
      check("midreset_state", 32'(state_dbg), 32'(IDLE));
      @(negedge axi_clk);
      axi_reset_n = 1'b1;
      r_block     = 1'b0;
      aw_delay    = 0;
      done_cnt    = 0;
      repeat (5) @(negedge axi_clk);
      check("postreset_no_done", 32'(done_cnt), 32'h0);
      check("postreset_outputs", 32'(outs()), 32'h0);
      check("postreset_state", 32'(state_dbg), 32'(IDLE));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fsic_serdes_cfg_master.md
Name: fsic_serdes_cfg_master

Overview:
AXI-Lite initiator that programs and confirms the IO SERDES control register (offset 0: bit0 rxen_ctl, bit1 txen_ctl).
- Issues one register write with the requested enables, then polls by read until the readback matches, bounded by retry and watchdog limits.
- Sits in the FSIC config path (axi_clk domain) and drives the SERDES AXI-Lite slave port plus its cc_is_enable select.

Parameters:
- pADDR_WIDTH, 15: AXI-Lite address width (byte address).
- pDATA_WIDTH, 32: AXI-Lite data width.
- pREG_OFFSET, 0: byte address of the control register.
- pMAX_RETRY, 7: readback attempts before error.
- pTIMEOUT, 255: maximum cycles to wait for any single handshake.

Ports:
- axi_clk  input  1  clock.
- axi_reset_n  input  1  reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- cfg_rxen  input  1  rxen_ctl value to program.
- cfg_txen  input  1  txen_ctl value to program.
- busy  output  1  high from the accepted start until DONE/ERR.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  level; set on failure, cleared by the next accepted start.
- rd_data  output  pDATA_WIDTH  last captured read data.
- cc_is_enable  output  1  slave select; high in WR, RD_A and RD_D only.
- axi_awvalid  output  1  write address valid.
- axi_awaddr  output  pADDR_WIDTH  write address; constant pREG_OFFSET.
- axi_awready  input  1  write address ready.
- axi_wvalid  output  1  write data valid.
- axi_wdata  output  pDATA_WIDTH  {30'b0, txen, rxen}.
- axi_wstrb  output  pDATA_WIDTH/8  all ones.
- axi_wready  input  1  write data ready.
- axi_arvalid  output  1  read address valid.
- axi_araddr  output  pADDR_WIDTH  read address; constant pREG_OFFSET.
- axi_arready  input  1  read address ready.
- axi_rvalid  input  1  read data valid.
- axi_rdata  input  pDATA_WIDTH  read data.
- axi_rready  output  1  read data ready.

Behaviour:
- Reset (axi_reset_n asynchronous, active-low, clock axi_clk): state IDLE; all valid/ready outputs, busy, done, error, cc_is_enable = 0; rd_data = 0; counters = 0.
- IDLE:
  - start=1 latches cfg_rxen/cfg_txen, clears error, zeros the retry counter, sets busy, and moves to WR.
  - start while busy is ignored.
- WR:
  - axi_awvalid and axi_wvalid assert together in the cycle after start.
  - Each channel is tracked independently by aw_done/w_done flags; a valid drops in the cycle after its own valid&ready.
  - Both done → RD_A.
  - Simultaneous awready and wready in one cycle completes WR in that cycle.
- RD_A: axi_arvalid=1 until arready is sampled → RD_D. Minimum 1 cycle.
- RD_D:
  - axi_rready=1; on rvalid, capture axi_rdata into rd_data → CHECK.
  - rvalid coincident with the RD_D entry cycle is accepted.
- CHECK (1 cycle):
  - rd_data[1:0] == {txen, rxen} → DONE.
  - Otherwise retry_cnt+1; if retry_cnt == pMAX_RETRY → ERR, else → RD_A.
- DONE: done=1 for one cycle, busy drops the same cycle → IDLE.
- ERR: error=1 (held), busy drops → IDLE.
- Watchdog:
  - Cycle counter cleared on every state entry.
  - Reaching pTIMEOUT while in WR/RD_A/RD_D forces all valids low the next cycle and → ERR.
  - Counter saturates and never wraps.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous); no completion pulse.
- Latency with an always-ready slave: start → done = 6 cycles (WR 1, RD_A 1, RD_D 1, CHECK 1, DONE 1, plus 1 registration cycle).

Optional Feature:
FSIC_SERDES_CFG_READBACK_EN
- Defined: read/verify loop as above.
- Undefined: WR completion → DONE directly; RD_A/RD_D/CHECK are absent; rd_data stays 0; arvalid and rready are tied 0; pMAX_RETRY is unused.

Decomposition:
- Package fsic_serdes_cfg_pkg holds:
  - state encoding (IDLE, WR, RD_A, RD_D, CHECK, DONE, ERR, 3 bits);
  - RXEN_BIT=0, TXEN_BIT=1;
  - default register offset.
- Sub-module fsic_cfg_watchdog: saturating counter with clear input, parameter pTIMEOUT, output expired.

Test Plan:
- Always-ready slave, start with cfg_rxen=1, cfg_txen=1 → wdata=0x3, wstrb=0xF, awaddr=0; read returns 0x3; done pulses at cycle 6; error=0.
- awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles; single write; done asserted.
- Slave returns 0x1 twice then 0x3 → two extra RD_A/RD_D rounds; done asserted; rd_data=0x3.
- Slave always returns 0x0 with cfg=0x2 → 8 reads (pMAX_RETRY+1); error=1; done never pulses.
- arready held 0 → ERR after 255 cycles; arvalid low next cycle; next start clears error.
- start asserted while busy, and axi_reset_n pulsed in RD_D → start ignored; after reset all outputs 0 and state IDLE.
